// File: rtl/io_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_regfile_pkg
// Description : Shared constants and address helpers for the sampled-input
//               register file (status bit positions, zero register, STAT and
//               first general-purpose addresses).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package io_regfile_pkg;

  // Bit positions inside the status register
  localparam int STAT_READY_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;

  // Hard-wired zero register
  localparam int ZERO_REG_ADDR  = 0;

  // STAT sits directly after the input registers r1..rNUM_IN
  function automatic int stat_addr(input int num_in);
    return num_in + 1;
  endfunction

  // General-purpose registers start right after STAT
  function automatic int first_gp_addr(input int num_in);
    return num_in + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : io_sample_timer
// Description : Wrap counter 0..SAMPLE_DIV-1 producing a one-cycle sample
//               strobe in the cycle where the count reaches SAMPLE_DIV-1.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module io_sample_timer #(
  parameter int SAMPLE_DIV = 500
) (
  input  logic clock,
  input  logic ctrl_reset,
  output logic strobe
);

  localparam int                c_cnt_w = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SAMPLE_DIV - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               w_last;

  assign w_last = (r_count == c_last);

  // Free-running wrap counter; reset discards any partial count
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Suppress the strobe while reset is held so no sample is taken mid-reset
  assign strobe = w_last & ~ctrl_reset;

endmodule
`default_nettype wire

// File: rtl/io_regfile.sv
`default_nettype none
// ============================================================================
// Module      : io_regfile
// Description : Parametrised register file with r0 tied to zero, sampled
//               read-only input registers r1..rNUM_IN, a READY/OVERRUN status
//               register (write-1-to-clear) and general-purpose registers.
//               Optional macro IO_REGFILE_BYPASS_EN forwards write data to a
//               same-cycle read of the same general-purpose address.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module io_regfile
  import io_regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_IN     = 3,
  parameter int IN_W       = 8,
  parameter int SAMPLE_DIV = 500,
  parameter int DEBUG_REG  = 5
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   ctrl_writeEnable,
  input  logic [ADDR_W-1:0]      ctrl_writeReg,
  input  logic [DATA_W-1:0]      data_writeReg,
  input  logic [ADDR_W-1:0]      ctrl_readRegA,
  input  logic [ADDR_W-1:0]      ctrl_readRegB,
  output logic [DATA_W-1:0]      data_readRegA,
  output logic [DATA_W-1:0]      data_readRegB,
  input  logic [NUM_IN*IN_W-1:0] ext_in,
  output logic                   sample_ready,
  output logic [15:0]            testing
);

  localparam int c_stat_addr = stat_addr(NUM_IN);
  localparam int c_first_gp  = first_gp_addr(NUM_IN);
  localparam int c_num_gp    = NUM_REGS - c_first_gp;

  // --------------------------------------------------------------------------
  // Sample timer
  // --------------------------------------------------------------------------
  logic w_strobe;

  io_sample_timer #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_timer (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .strobe     (w_strobe)
  );

  // --------------------------------------------------------------------------
  // Input channels: two-flop synchronizer, then capture on the strobe
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] r_sync1 [NUM_IN];
  logic [IN_W-1:0] r_sync2 [NUM_IN];
  logic [IN_W-1:0] r_in    [NUM_IN];

  generate
    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
      // Synchronize the raw pin and latch it into the input register on strobe
      always_ff @(posedge clock) begin
        if (ctrl_reset) begin
          r_sync1[k] <= '0;
          r_sync2[k] <= '0;
          r_in[k]    <= '0;
        end else begin
          r_sync1[k] <= ext_in[k*IN_W +: IN_W];
          r_sync2[k] <= r_sync1[k];
          if (w_strobe) begin
            r_in[k] <= r_sync2[k];
          end
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Status register: READY / OVERRUN with write-1-to-clear
  // --------------------------------------------------------------------------
  logic              w_stat_wr;
  logic              w_clr0;
  logic              w_clr1;
  logic              r_ready;
  logic              r_ovr;
  logic [DATA_W-1:0] w_stat_word;

  assign w_stat_wr = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(c_stat_addr));
  assign w_clr0    = w_stat_wr & data_writeReg[STAT_READY_BIT];
  assign w_clr1    = w_stat_wr & data_writeReg[STAT_OVR_BIT];

  // A clear landing together with the strobe acts as the acknowledge,
  // so READY stays set and no overrun is flagged
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ready <= w_strobe | (r_ready & ~w_clr0);
      r_ovr   <= (w_strobe & r_ready & ~w_clr0) | (r_ovr & ~w_clr1);
    end
  end

  // Pack the status bits into a full-width word; unused bits read zero
  always_comb begin
    w_stat_word                 = '0;
    w_stat_word[STAT_READY_BIT] = r_ready;
    w_stat_word[STAT_OVR_BIT]   = r_ovr;
  end

  assign sample_ready = r_ready;

  // --------------------------------------------------------------------------
  // General-purpose registers
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_gp [c_num_gp];

  generate
    for (genvar g = 0; g < c_num_gp; g++) begin : g_gp
      // Load on a write addressed to this register
      always_ff @(posedge clock) begin
        if (ctrl_reset) begin
          r_gp[g] <= '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(c_first_gp + g))) begin
          r_gp[g] <= data_writeReg;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Flat register view used by both read ports and the debug output
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_view [NUM_REGS];

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
      if (i == ZERO_REG_ADDR) begin : g_zero
        assign w_view[i] = '0;
      end else if (i <= NUM_IN) begin : g_input
        assign w_view[i] = DATA_W'(r_in[i-1]);
      end else if (i == c_stat_addr) begin : g_stat
        assign w_view[i] = w_stat_word;
      end else begin : g_gpr
        assign w_view[i] = r_gp[i-c_first_gp];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
`ifdef IO_REGFILE_BYPASS_EN
  logic w_wr_gp;

  assign w_wr_gp = ctrl_writeEnable && (ctrl_writeReg >= ADDR_W'(c_first_gp));

  // Forward in-flight write data only for general-purpose addresses
  always_comb begin
    data_readRegA = w_view[ctrl_readRegA];
    data_readRegB = w_view[ctrl_readRegB];
    if (w_wr_gp && (ctrl_readRegA == ctrl_writeReg)) begin
      data_readRegA = data_writeReg;
    end
    if (w_wr_gp && (ctrl_readRegB == ctrl_writeReg)) begin
      data_readRegB = data_writeReg;
    end
  end
`else
  assign data_readRegA = w_view[ctrl_readRegA];
  assign data_readRegB = w_view[ctrl_readRegB];
`endif

  assign testing = w_view[DEBUG_REG][15:0];

endmodule
`default_nettype wire
